// File: rtl/pll_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_pkg
// Purpose  : Shared PLL reconfig register map, writer states and beat type.
// Revision : 1.0
// ============================================================================
package pll_cfg_pkg;

    localparam logic [5:0] c_ADDR_MODE    = 6'd0;
    localparam logic [5:0] c_ADDR_STATUS  = 6'd1;
    localparam logic [5:0] c_ADDR_START   = 6'd2;
    localparam logic [5:0] c_ADDR_N       = 6'd3;
    localparam logic [5:0] c_ADDR_M       = 6'd4;
    localparam logic [5:0] c_ADDR_C       = 6'd5;
    localparam logic [5:0] c_ADDR_DPS     = 6'd6;
    localparam logic [5:0] c_ADDR_MFRAC   = 6'd7;
    localparam logic [5:0] c_ADDR_BW      = 6'd8;
    localparam logic [5:0] c_ADDR_CP      = 6'd9;
    localparam logic [5:0] c_ADDR_VCO_DIV = 6'd28;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_MODE    = 3'd2,
        S_WRITE   = 3'd3,
        S_START   = 3'd4,
        S_GUARD   = 3'd5,
        S_LOCK    = 3'd6
    } state_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/pll_cfg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_fifo
// Purpose  : DEPTH-entry synchronous beat FIFO, first-word-fall-through read.
// Revision : 1.0
// ============================================================================
module pll_cfg_fifo
    import pll_cfg_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  beat_t                  i_push_beat,
    input  logic                   i_pop,
    output beat_t                  o_pop_beat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    beat_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full     = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_beat = r_mem[r_rd_ptr];
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_beat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_writer
// Purpose  : Buffers a batch of PLL register writes, replays it on the Avalon
//            reconfig port framed by mode/start writes, then waits for relock.
// Revision : 1.0
// ============================================================================
module pll_cfg_writer
    import pll_cfg_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int LOCK_GUARD   = 16,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [5:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        cfg_last,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int                 c_CNT_W      = $clog2(DEPTH) + 1;
    localparam int                 c_TMO_W      = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX    = c_TMO_W'(LOCK_TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_GUARD_LAST = c_TMO_W'(LOCK_GUARD - 1);
    localparam logic [c_CNT_W-1:0] c_FILL_LAST  = c_CNT_W'(DEPTH - 1);

    state_t             r_state;
    logic               r_cfg_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [5:0]         r_mgmt_address;
    logic [31:0]        r_mgmt_writedata;
    logic               r_mgmt_write;
    logic               r_lock_meta;
    logic               r_lock_sync;
    logic [1:0]         r_qual;
    logic [c_TMO_W-1:0] r_tmo;

    beat_t              w_push_beat;
    beat_t              w_head;
    logic               w_full;
    logic               w_empty;
    logic [c_CNT_W-1:0] w_count;
    logic               w_accept;
    logic               w_fill_last;
    logic               w_wr_done;
    logic               w_pop;
    logic               w_waiting;
    logic               w_lock_ok;
    logic               w_timeout;
    logic               w_finish;

    assign cfg_ready      = r_cfg_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign mgmt_address   = r_mgmt_address;
    assign mgmt_writedata = r_mgmt_writedata;
    assign mgmt_write     = r_mgmt_write;

    assign w_push_beat = '{addr: cfg_addr, data: cfg_data};
    assign w_accept    = cfg_valid && r_cfg_ready && !w_full;
    assign w_fill_last = (w_count == c_FILL_LAST);
    assign w_wr_done   = r_mgmt_write && !mgmt_waitrequest;
    assign w_pop       = w_wr_done && !w_empty
                         && ((r_state == S_MODE) || (r_state == S_WRITE));
    assign w_waiting   = (r_state == S_GUARD) || (r_state == S_LOCK);
    // A lock qualifying on the same cycle as the timeout counts as success.
    assign w_lock_ok   = (r_state == S_LOCK) && r_lock_sync && (r_qual == 2'd3);
    assign w_timeout   = w_waiting && (r_tmo >= c_TMO_LAST) && !w_lock_ok;
    assign w_finish    = w_lock_ok || w_timeout;

    pll_cfg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_finish),
        .i_push      (w_accept),
        .i_push_beat (w_push_beat),
        .i_pop       (w_pop),
        .o_pop_beat  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cfg_ready      <= 1'b1;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_mgmt_address   <= '0;
            r_mgmt_writedata <= '0;
            r_mgmt_write     <= 1'b0;
            r_lock_meta      <= 1'b0;
            r_lock_sync      <= 1'b0;
            r_qual           <= '0;
            r_tmo            <= '0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
            r_done      <= 1'b0;
            r_error     <= 1'b0;

            // r_tmo counts cycles since the start write completed.
            if (w_waiting && (r_tmo != c_TMO_MAX)) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end

            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (w_accept) begin
                        r_busy  <= 1'b1;
                        r_state <= S_COLLECT;
                        if (cfg_last || w_fill_last) begin
                            r_state          <= S_MODE;
                            r_cfg_ready      <= 1'b0;
                            r_mgmt_write     <= 1'b1;
                            r_mgmt_address   <= c_ADDR_MODE;
                            r_mgmt_writedata <= '0;
                        end
                    end
                end
                S_MODE, S_WRITE: begin
                    if (w_wr_done) begin
                        if (!w_empty) begin
                            r_state          <= S_WRITE;
                            r_mgmt_address   <= w_head.addr;
                            r_mgmt_writedata <= w_head.data;
                        end else begin
                            r_state          <= S_START;
                            r_mgmt_address   <= c_ADDR_START;
                            r_mgmt_writedata <= '0;
                        end
                    end
                end
                S_START: begin
                    if (w_wr_done) begin
                        r_mgmt_write <= 1'b0;
                        r_tmo        <= c_TMO_W'(1);
                        r_qual       <= '0;
                        r_state      <= (LOCK_GUARD <= 1) ? S_LOCK : S_GUARD;
                    end
                end
                S_GUARD, S_LOCK: begin
                    if (w_finish) begin
                        r_done      <= 1'b1;
                        r_error     <= w_timeout;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_state == S_GUARD) begin
                        if (r_tmo >= c_GUARD_LAST) begin
                            r_state <= S_LOCK;
                        end
                    end else begin
                        r_qual <= r_lock_sync ? (r_qual + 2'd1) : 2'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
